// File: rtl/inst_mem_loader.sv
// Boot loader for the instruction memory: assembles a byte stream into little-endian
// words, writes them out and verifies a trailing XOR checksum before releasing the core.
module inst_mem_loader #(
  parameter int unsigned DEPTH = 51,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W:0]   len_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      wdata_o,
  output logic             cpu_hold_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned LEN_W = CNT_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  state_t           state;
  state_t           next_state;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_q;
  logic [7:0]       csum;

  logic accept;
  logic len_ok;
  logic last_word;
  logic can_start;

  assign accept    = byte_valid_i & byte_ready_o;
  assign len_ok    = (len_i != '0) && (len_i <= LEN_W'(DEPTH));
  assign last_word = ({1'b0, word_idx} == (len_q - LEN_W'(1)));
  assign can_start = start_i && ((state == IDLE) || (state == DONE) || (state == ERR));

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_i) next_state = len_ok ? LOAD : ERR;
      end
      LOAD: begin
        if (accept && (byte_cnt == 2'd3) && last_word) next_state = CHECK;
      end
      CHECK: begin
        if (accept) next_state = (byte_data_i == csum) ? DONE : ERR;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, datapath and registered outputs; flags are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      csum         <= '0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      byte_ready_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      cpu_hold_o   <= 1'b1;
    end else begin
      state        <= next_state;
      byte_ready_o <= (next_state == LOAD) || (next_state == CHECK);
      done_o       <= (next_state == DONE);
      err_o        <= (next_state == ERR);
      cpu_hold_o   <= (next_state != DONE);
      we_o         <= 1'b0;

      if (can_start && len_ok) begin
        len_q    <= len_i;
        word_idx <= '0;
        byte_cnt <= '0;
        asm_q    <= '0;
        csum     <= '0;
      end

      if ((state == LOAD) && accept) begin
        csum <= csum ^ byte_data_i;
        if (byte_cnt == 2'd3) begin
          we_o     <= 1'b1;
          waddr_o  <= 32'({word_idx, 2'b00});
          wdata_o  <= {byte_data_i, asm_q};
          word_idx <= word_idx + CNT_W'(1);
          byte_cnt <= '0;
        end else begin
          case (byte_cnt)
            2'd0:    asm_q[7:0]   <= byte_data_i;
            2'd1:    asm_q[15:8]  <= byte_data_i;
            default: asm_q[23:16] <= byte_data_i;
          endcase
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule
